// File: rtl/data_io_if.sv
// Sequencer-side bundle for data_io: byte selects, drive/capture enables,
// the outgoing shift-register byte and the captured incoming byte.
interface data_io_if;
  logic       SelData;
  logic       SelAA;
  logic       Sel55;
  logic       SelB0;
  logic       SelC0;
  logic       SelD0;
  logic       SelE0;
  logic       Sel00;
  logic [7:0] ShiftRegOut;
  logic       EnDataOut;
  logic       EnDataIn;
  logic [7:0] ShiftRegIn;

  // Command sequencer side
  modport master (
    output SelData, SelAA, Sel55, SelB0, SelC0, SelD0, SelE0, Sel00,
    output ShiftRegOut, EnDataOut, EnDataIn,
    input  ShiftRegIn
  );

  // data_io side
  modport slave (
    input  SelData, SelAA, Sel55, SelB0, SelC0, SelD0, SelE0, Sel00,
    input  ShiftRegOut, EnDataOut, EnDataIn,
    output ShiftRegIn
  );
endinterface

// File: rtl/data_io.sv
// data_io: byte-wide path between the flash command sequencer and the
// flash device's bidirectional IO bus. Drives either the shift-register
// byte or a fixed command/unlock constant, or captures IO into ShiftRegIn.
// IO is kept as a direct inout port so the tri-state net resolves at the
// pad rather than inside the sequencer bundle.
module data_io (
  input  logic       SCL,
  input  logic       nReset,
  data_io_if.slave   bus,
  inout  wire  [7:0] IO
);

  logic [7:0] outReg_q;
  logic [7:0] outReg_d;
  logic [7:0] shiftRegIn_q;
  logic [7:0] shiftRegIn_d;

  // Pick the next output byte by select priority; hold when not driving or nothing selected
  always_comb begin
    outReg_d = outReg_q;
    if (bus.EnDataOut) begin
      if (bus.SelData)    outReg_d = bus.ShiftRegOut;
      else if (bus.SelAA) outReg_d = 8'hAA;
      else if (bus.Sel55) outReg_d = 8'h55;
      else if (bus.SelB0) outReg_d = 8'hB0;
      else if (bus.SelC0) outReg_d = 8'hC0;
      else if (bus.SelD0) outReg_d = 8'hD0;
      else if (bus.SelE0) outReg_d = 8'hE0;
      else if (bus.Sel00) outReg_d = 8'h00;
    end
  end

  // Capture IO only when not driving it, so our own drive is never sampled
  always_comb begin
    shiftRegIn_d = shiftRegIn_q;
    if (bus.EnDataIn && !bus.EnDataOut) begin
      shiftRegIn_d = IO;
    end
  end

  // Output and input byte registers, cleared asynchronously by reset
  always_ff @(posedge SCL or negedge nReset) begin
    if (!nReset) begin
      outReg_q     <= 8'h00;
      shiftRegIn_q <= 8'h00;
    end else begin
      outReg_q     <= outReg_d;
      shiftRegIn_q <= shiftRegIn_d;
    end
  end

  // Driver follows the enable combinationally and is forced off during reset
  assign IO             = (nReset && bus.EnDataOut) ? outReg_q : 8'bz;
  assign bus.ShiftRegIn = shiftRegIn_q;

endmodule

// File: tb/tb_data_io.sv
// Testbench for data_io: directed scenarios followed by random cycles,
// all checked against a select-table model of the output and input bytes.
module tb_data_io;

  logic       SCL;
  logic       nReset;
  logic [7:0] sel;
  logic [7:0] tbDrv;
  logic       tbDrvEn;
  wire  [7:0] IO;

  data_io_if ifc ();

  // sel bit order is the select priority order, highest first
  assign ifc.SelData = sel[0];
  assign ifc.SelAA   = sel[1];
  assign ifc.Sel55   = sel[2];
  assign ifc.SelB0   = sel[3];
  assign ifc.SelC0   = sel[4];
  assign ifc.SelD0   = sel[5];
  assign ifc.SelE0   = sel[6];
  assign ifc.Sel00   = sel[7];

  assign IO = tbDrvEn ? tbDrv : 8'bz;

  data_io dut (
    .SCL    (SCL),
    .nReset (nReset),
    .bus    (ifc.slave),
    .IO     (IO)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mOut;
  logic [7:0] mIn;
  logic [7:0] constTab [8];

  initial SCL = 1'b0;
  always #5 SCL = ~SCL;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One SCL cycle: drive after a falling edge, update model at the rising edge, check after it
  task automatic applyStimulus(input logic [7:0] s, input logic eo, input logic ei,
                               input logic [7:0] sro, input logic [7:0] drv);
    logic [7:0] nextOut;
    sel             = s;
    ifc.EnDataOut   = eo;
    ifc.EnDataIn    = ei;
    ifc.ShiftRegOut = sro;
    tbDrv           = drv;
    tbDrvEn         = !eo;
    #1;
    if (eo) checkOutput("IO_pre_edge", IO, mOut);
    @(posedge SCL);
    nextOut = mOut;
    if (eo) begin
      for (int i = 7; i >= 0; i--) begin
        if (s[i]) nextOut = (i == 0) ? sro : constTab[i];
      end
    end else if (ei) begin
      mIn = drv;
    end
    mOut = nextOut;
    #1;
    checkOutput("ShiftRegIn", ifc.ShiftRegIn, mIn);
    if (eo) checkOutput("IO_drive", IO, mOut);
    else    checkOutput("IO_release", IO, drv);
    @(negedge SCL);
  endtask

  initial begin
    constTab = '{8'h00, 8'hAA, 8'h55, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'h00};
    mOut = 8'h00;
    mIn  = 8'h00;

    // Reset with drive enabled: DUT must release IO and clear ShiftRegIn
    nReset          = 1'b0;
    sel             = 8'h01;
    ifc.EnDataOut   = 1'b1;
    ifc.EnDataIn    = 1'b0;
    ifc.ShiftRegOut = 8'hA7;
    tbDrv           = 8'h96;
    tbDrvEn         = 1'b1;
    #2;
    checkOutput("reset_ShiftRegIn", ifc.ShiftRegIn, 8'h00);
    checkOutput("reset_IO_released", IO, 8'h96);
    tbDrvEn = 1'b0;
    @(negedge SCL);
    nReset = 1'b1;
    applyStimulus(8'h01, 1'b1, 1'b0, 8'hA7, 8'h00);

    // Constant walk, one-hot per cycle
    for (int i = 0; i < 8; i++) applyStimulus(8'(1 << i), 1'b1, 1'b0, 8'hF0, 8'h00);

    // Priority
    applyStimulus(8'h03, 1'b1, 1'b0, 8'h3C, 8'h00);
    applyStimulus(8'h82, 1'b1, 1'b0, 8'h3C, 8'h00);

    // Hold after 55
    applyStimulus(8'h04, 1'b1, 1'b0, 8'h11, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1, 1'b0, 8'h11, 8'h00);

    // Read, then no capture with EnDataIn low
    applyStimulus(8'hFF, 1'b0, 1'b1, 8'h22, 8'h5A);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h22, 8'hC3);

    // Contention: output wins, no capture
    applyStimulus(8'h20, 1'b1, 1'b1, 8'h22, 8'h00);

    // Mid-operation reset: load both registers, then reset between edges
    applyStimulus(8'h01, 1'b1, 1'b0, 8'h77, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b1, 8'h00, 8'h4E);
    sel           = 8'h01;
    ifc.EnDataOut = 1'b1;
    ifc.EnDataIn  = 1'b0;
    tbDrv         = 8'h3C;
    tbDrvEn       = 1'b1;
    #2;
    nReset = 1'b0;
    #1;
    checkOutput("midreset_ShiftRegIn", ifc.ShiftRegIn, 8'h00);
    checkOutput("midreset_IO_released", IO, 8'h3C);
    mOut = 8'h00;
    mIn  = 8'h00;
    tbDrvEn = 1'b0;
    @(negedge SCL);
    nReset = 1'b1;
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00, 8'h00);

    // Random cycles
    for (int n = 0; n < 300; n++) begin
      applyStimulus(8'($urandom_range(0, 255) & $urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
